// File: rtl/nand_data_tx_if.sv
// Bus bundle for nand_data_tx: command handshake, data-buffer read port and
// NAND data-input pads. The streamer connects through the slave modport.
interface nand_data_tx_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 13
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic             err_uflow;
  logic             fifo_rempty;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] nand_dq_o;
  logic             nand_dq_oe;
  logic             nand_we_n;

  modport master (
    output start, len, fifo_rempty, fifo_dout,
    input  busy, done, err_uflow, fifo_rd_en, nand_dq_o, nand_dq_oe, nand_we_n
  );

  modport slave (
    input  start, len, fifo_rempty, fifo_dout,
    output busy, done, err_uflow, fifo_rd_en, nand_dq_o, nand_dq_oe, nand_we_n
  );
endinterface

// File: rtl/nand_data_tx.sv
// Program-path data streamer: pops the page buffer (show-ahead read port) and
// drives one NAND data-input write cycle (DQ + WE#) per byte until the
// commanded count is sent.
// Optional feature: define NAND_DATA_TX_UFLOW_TO_EN to abort with err_uflow
// after TO_CYC consecutive empty-buffer cycles while waiting for a byte.
module nand_data_tx #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LEN_W  = 13,
  parameter int unsigned TWP    = 2,
  parameter int unsigned TWH    = 2,
  parameter int unsigned TO_CYC = 1024
) (
  input  logic          clk,
  input  logic          rst,
  nand_data_tx_if.slave bus
);

  localparam int unsigned PH_MAX = (TWP > TWH) ? TWP : TWH;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  // Reject pulse widths and timeout that the phase logic cannot represent.
  if (TWP < 1 || TWH < 1 || TO_CYC < 1) begin : g_param_chk
    $error("nand_data_tx: TWP, TWH and TO_CYC must all be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WLOW,
    S_WHIGH,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic             oe_q, oe_d;
  logic             we_n_q, we_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_en_c;

`ifdef NAND_DATA_TX_UFLOW_TO_EN
  localparam int unsigned TO_W = $clog2(TO_CYC + 1);
  logic [TO_W-1:0] to_q, to_d, to_inc;
  logic            err_q, err_d;
`endif

  // Next-state, byte fetch, phase timing and registered-output decode.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ph_d    = ph_q;
    dq_d    = dq_q;
    rd_en_c = 1'b0;
`ifdef NAND_DATA_TX_UFLOW_TO_EN
    to_d    = '0;
    err_d   = 1'b0;
    to_inc  = (to_q == TO_W'(TO_CYC)) ? to_q : to_q + TO_W'(1);
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            rem_d   = bus.len;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        if (!bus.fifo_rempty) begin
          rd_en_c = 1'b1;
          dq_d    = bus.fifo_dout;
          if (rem_q != '0) begin
            rem_d = rem_q - LEN_W'(1);
          end
          ph_d    = PH_W'(TWP - 1);
          state_d = S_WLOW;
        end
`ifdef NAND_DATA_TX_UFLOW_TO_EN
        else if (to_inc == TO_W'(TO_CYC)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          to_d = to_inc;
        end
`endif
      end
      S_WLOW: begin
        if (ph_q == '0) begin
          ph_d    = PH_W'(TWH - 1);
          state_d = S_WHIGH;
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
      end
      S_WHIGH: begin
        if (ph_q == '0) begin
          state_d = (rem_q != '0) ? S_FETCH : S_DONE;
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    oe_d   = (state_d == S_FETCH) || (state_d == S_WLOW) || (state_d == S_WHIGH);
    we_n_d = (state_d != S_WLOW);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      ph_q    <= '0;
      dq_q    <= '0;
      oe_q    <= 1'b0;
      we_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef NAND_DATA_TX_UFLOW_TO_EN
      to_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ph_q    <= ph_d;
      dq_q    <= dq_d;
      oe_q    <= oe_d;
      we_n_q  <= we_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef NAND_DATA_TX_UFLOW_TO_EN
      to_q    <= to_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.fifo_rd_en = rd_en_c;
  assign bus.nand_dq_o  = dq_q;
  assign bus.nand_dq_oe = oe_q;
  assign bus.nand_we_n  = we_n_q;
`ifdef NAND_DATA_TX_UFLOW_TO_EN
  assign bus.err_uflow  = err_q;
`else
  assign bus.err_uflow  = 1'b0;
`endif

endmodule

// File: tb/tb_nand_data_tx.sv
// Self-checking bench for nand_data_tx: buffer model, WE#/DQ monitor,
// directed vector table plus hand-written multi-cycle sequences.
module tb_nand_data_tx;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LEN_W = 13;
  localparam int unsigned TWP   = 2;
  localparam int unsigned TWH   = 2;
`ifdef NAND_DATA_TX_UFLOW_TO_EN
  localparam int unsigned TO_CYC = 16;
`else
  localparam int unsigned TO_CYC = 1024;
`endif
  localparam int unsigned DEPTH = 16384;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nand_data_tx_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) intf ();

  nand_data_tx #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W),
    .TWP   (TWP),
    .TWH   (TWH),
    .TO_CYC(TO_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(intf)
  );

  // Buffer model (show-ahead) and scoreboard storage.
  logic [7:0]  mem  [0:DEPTH-1];
  logic [7:0]  expd [0:DEPTH-1];
  logic [7:0]  cap  [0:DEPTH-1];
  logic [31:0] wr_ptr = 0;
  logic [31:0] rd_ptr = 0;
  int exp_wr = 0, exp_rd = 0, cap_base = 0;

  int pop_cnt = 0, pop_bad = 0;
  int pulse_cnt = 0, width_err = 0, dq_err = 0, cap_cnt = 0, err_seen = 0, low_len = 0;
  logic       prev_we = 1'b1;
  logic [7:0] dq_fall = 8'h00;

  int n_chk = 0, n_fail = 0;

  assign intf.fifo_rempty = (rd_ptr == wr_ptr);
  assign intf.fifo_dout   = mem[rd_ptr[13:0]];

  always @(posedge clk) begin
    if (intf.fifo_rd_en) begin
      pop_cnt <= pop_cnt + 1;
      if (intf.fifo_rempty) pop_bad <= pop_bad + 1;
      else rd_ptr <= rd_ptr + 1;
    end
  end

  // WE# pulse monitor: counts pulses, checks low width and DQ stability,
  // captures DQ at each WE# rising edge.
  always @(negedge clk) begin
    if (intf.err_uflow) err_seen <= err_seen + 1;
    if (prev_we && !intf.nand_we_n) begin
      pulse_cnt <= pulse_cnt + 1;
      low_len   <= 1;
      dq_fall   <= intf.nand_dq_o;
    end else if (!intf.nand_we_n) begin
      low_len <= low_len + 1;
      if (intf.nand_dq_o != dq_fall) dq_err <= dq_err + 1;
    end
    if (!prev_we && intf.nand_we_n) begin
      if (low_len != int'(TWP)) width_err <= width_err + 1;
      cap[14'(cap_cnt)] <= intf.nand_dq_o;
      cap_cnt <= cap_cnt + 1;
    end
    prev_we <= intf.nand_we_n;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[13:0]]  = b;
    expd[14'(exp_wr)]  = b;
    exp_wr++;
    wr_ptr = wr_ptr + 1;
  endtask

  // Returns with the caller at the negedge of cycle N+1 (k = 1).
  task automatic do_start(input int l);
    @(negedge clk);
    intf.start = 1'b1;
    intf.len   = LEN_W'(l);
    @(negedge clk);
    intf.start = 1'b0;
  endtask

  task automatic wait_done(input int k0, input int kmax, output int lat, output logic err);
    int k;
    k   = k0;
    lat = -1;
    err = 1'b0;
    while (k <= kmax) begin
      if (intf.done) begin
        lat = k;
        err = intf.err_uflow;
        break;
      end
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_data(input string nm, input int n);
    int mism;
    mism = 0;
    for (int i = 0; i < n; i++)
      if (cap[14'(cap_base + i)] !== expd[14'(exp_rd + i)]) mism++;
    check({nm, "_bytes"}, 32'(cap_cnt - cap_base), 32'(n));
    check({nm, "_data"}, 32'(mism), 0);
    cap_base = cap_cnt;
    exp_rd   = exp_rd + n;
  endtask

  typedef struct {
    int         len;
    int         npush;
    logic [7:0] base;
    int         pops;
    int         lat;
    int         left;
  } vec_t;

  vec_t vecs [7];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   lat, p0, w0, e0;
    logic errf;

    vecs[0] = '{len: 1, npush: 1, base: 8'hA5, pops: 1, lat: 6,  left: 0};
    vecs[1] = '{len: 3, npush: 3, base: 8'h11, pops: 3, lat: 16, left: 0};
    vecs[2] = '{len: 0, npush: 0, base: 8'h00, pops: 0, lat: 1,  left: 0};
    vecs[3] = '{len: 2, npush: 4, base: 8'h40, pops: 2, lat: 11, left: 2};
    vecs[4] = '{len: 2, npush: 0, base: 8'h00, pops: 2, lat: 11, left: 0};
    vecs[5] = '{len: 0, npush: 2, base: 8'h77, pops: 0, lat: 1,  left: 2};
    vecs[6] = '{len: 2, npush: 0, base: 8'h00, pops: 2, lat: 11, left: 0};

    rst        = 1'b1;
    intf.start = 1'b0;
    intf.len   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(intf.busy), 0);
    check("rst_done",  32'(intf.done), 0);
    check("rst_err",   32'(intf.err_uflow), 0);
    check("rst_rd_en", 32'(intf.fifo_rd_en), 0);
    check("rst_dq",    32'(intf.nand_dq_o), 0);
    check("rst_oe",    32'(intf.nand_dq_oe), 0);
    check("rst_we_n",  32'(intf.nand_we_n), 1);
    rst = 1'b0;
    @(negedge clk);

    // Cycle-exact timing of a single byte.
    push(8'h5A);
    p0 = pop_cnt;
    do_start(1);
    check("t1_busy", 32'(intf.busy), 1);
    check("t1_we_n", 32'(intf.nand_we_n), 1);
    check("t1_oe",   32'(intf.nand_dq_oe), 1);
    check("t1_rd_en", 32'(intf.fifo_rd_en), 1);
    @(negedge clk);
    check("t2_we_n", 32'(intf.nand_we_n), 0);
    check("t2_dq",   32'(intf.nand_dq_o), 32'h5A);
    @(negedge clk);
    check("t3_we_n", 32'(intf.nand_we_n), 0);
    @(negedge clk);
    check("t4_we_n", 32'(intf.nand_we_n), 1);
    check("t4_dq",   32'(intf.nand_dq_o), 32'h5A);
    @(negedge clk);
    check("t5_done", 32'(intf.done), 0);
    @(negedge clk);
    check("t6_done", 32'(intf.done), 1);
    check("t6_busy", 32'(intf.busy), 1);
    check("t6_oe",   32'(intf.nand_dq_oe), 0);
    @(negedge clk);
    check("t7_done", 32'(intf.done), 0);
    check("t7_busy", 32'(intf.busy), 0);
    check("t_pops",  32'(pop_cnt - p0), 1);
    check_data("t", 1);

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < vecs[i].npush; j++) push(vecs[i].base + 8'(j * 17));
      p0 = pop_cnt;
      w0 = pulse_cnt;
      e0 = width_err;
      do_start(vecs[i].len);
      wait_done(1, 5 * vecs[i].len + 20, lat, errf);
      @(negedge clk);
      check($sformatf("v%0d_lat", i),    32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_pops", i),   32'(pop_cnt - p0), 32'(vecs[i].pops));
      check($sformatf("v%0d_pulses", i), 32'(pulse_cnt - w0), 32'(vecs[i].pops));
      check($sformatf("v%0d_width", i),  32'(width_err - e0), 0);
      check($sformatf("v%0d_left", i),   wr_ptr - rd_ptr, 32'(vecs[i].left));
      check($sformatf("v%0d_busy", i),   32'(intf.busy), 0);
      check_data($sformatf("v%0d", i), vecs[i].pops);
    end

`ifdef NAND_DATA_TX_UFLOW_TO_EN
    // Underflow timeout: one byte of four available.
    push(8'h3C);
    p0 = pop_cnt;
    do_start(4);
    wait_done(1, 60, lat, errf);
    check("uf_lat",  32'(lat), 22);
    check("uf_err",  32'(errf), 1);
    @(negedge clk);
    check("uf_pops", 32'(pop_cnt - p0), 1);
    check("uf_done_clr", 32'(intf.done), 0);
    check("uf_err_clr",  32'(intf.err_uflow), 0);
    check("uf_busy", 32'(intf.busy), 0);
    check_data("uf", 1);
`else
    // Buffer runs dry after byte 1 for well over 20 cycles, then refills.
    push(8'h3C);
    p0 = pop_cnt;
    w0 = pulse_cnt;
    do_start(3);
    repeat (25) @(negedge clk);
    check("st_pulses", 32'(pulse_cnt - w0), 1);
    check("st_pops",   32'(pop_cnt - p0), 1);
    check("st_we_n",   32'(intf.nand_we_n), 1);
    check("st_oe",     32'(intf.nand_dq_oe), 1);
    check("st_dq",     32'(intf.nand_dq_o), 32'h3C);
    check("st_busy",   32'(intf.busy), 1);
    push(8'h4D);
    push(8'h5E);
    wait_done(26, 80, lat, errf);
    @(negedge clk);
    check("st_done_seen", 32'(lat > 0), 1);
    check("st_pops_end",  32'(pop_cnt - p0), 3);
    check("st_pulses_end", 32'(pulse_cnt - w0), 3);
    check_data("st", 3);
`endif

    // Reset during byte 2 of 5.
    for (int j = 0; j < 5; j++) push(8'hC0 + 8'(j));
    p0 = pop_cnt;
    do_start(5);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rs_we_n", 32'(intf.nand_we_n), 1);
    check("rs_oe",   32'(intf.nand_dq_oe), 0);
    check("rs_busy", 32'(intf.busy), 0);
    check("rs_done", 32'(intf.done), 0);
    check("rs_dq",   32'(intf.nand_dq_o), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rs_pops", 32'(pop_cnt - p0), 2);
    check("rs_left", wr_ptr - rd_ptr, 3);
    cap_base = cap_cnt;
    exp_rd   = exp_rd + 2;

    // Full-range count with an ignored start while busy; 3 leftover bytes
    // from the aborted command are streamed first.
    for (int j = 0; j < 8188; j++) push(8'(j * 7 + 3));
    p0 = pop_cnt;
    w0 = pulse_cnt;
    e0 = width_err;
    do_start(8191);
    @(negedge clk);
    intf.start = 1'b1;
    intf.len   = LEN_W'(3);
    @(negedge clk);
    intf.start = 1'b0;
    wait_done(3, 41000, lat, errf);
    @(negedge clk);
    check("big_lat",    32'(lat), 40956);
    check("big_pops",   32'(pop_cnt - p0), 8191);
    check("big_pulses", 32'(pulse_cnt - w0), 8191);
    check("big_width",  32'(width_err - e0), 0);
    check("big_left",   wr_ptr - rd_ptr, 0);
    check("big_busy",   32'(intf.busy), 0);
    check_data("big", 8191);

    check("dq_stable",  32'(dq_err), 0);
    check("pop_empty",  32'(pop_bad), 0);
`ifdef NAND_DATA_TX_UFLOW_TO_EN
    check("err_pulses", 32'(err_seen), 1);
`else
    check("err_pulses", 32'(err_seen), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nand_data_tx.md
# nand_data_tx

Program-path data streamer for the NAND controller. It drains the page data buffer from its read side and drives NAND data-input write cycles (DQ plus WE#), one byte per cycle pair, until a commanded byte count is sent. It sits between the data buffer's read port (show-ahead: `dout` is valid whenever `rempty` is low) and the NAND pad interface, and is started by the command sequencer after the program command and address cycles.

## Interface
Parameters:
- `WIDTH`, 8: DQ and buffer data width.
- `LEN_W`, 13: byte-count width.
- `TWP`, 2: WE# low time in clk cycles, ≥1.
- `TWH`, 2: WE# high time in clk cycles, ≥1.
- `TO_CYC`, 1024: underflow timeout in cycles (used only with the macro).

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: one-cycle start request.
- `len` in LEN_W: bytes to send; sampled when `start` is accepted.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle completion pulse.
- `err_uflow` out 1: one-cycle underflow abort pulse, coincident with `done`.
- `fifo_rempty` in 1: buffer empty flag.
- `fifo_dout` in WIDTH: buffer head data (show-ahead).
- `fifo_rd_en` out 1: pops the buffer head.
- `nand_dq_o` out WIDTH: DQ output data, registered.
- `nand_dq_oe` out 1: DQ output enable.
- `nand_we_n` out 1: NAND WE#, active low.

## Operation
- States are IDLE, FETCH, WLOW, WHIGH and DONE.
- IDLE:
  - `start` with `len != 0` latches `rem = len` and goes to FETCH.
  - `start` with `len == 0` goes to DONE. No WE# pulse and no pop occur.
  - `start` outside IDLE is ignored.
- FETCH:
  - `nand_dq_oe = 1` and `nand_we_n = 1`.
  - If `!fifo_rempty`, `fifo_rd_en = 1` combinationally in this cycle, `nand_dq_o <= fifo_dout`, `rem <= rem - 1`, and the block goes to WLOW.
  - Otherwise it stays in FETCH with `fifo_rd_en = 0`.
- WLOW: `nand_we_n = 0` for exactly TWP cycles, then WHIGH. `nand_dq_o` is held stable.
- WHIGH:
  - `nand_we_n = 1` for exactly TWH cycles. `nand_dq_o` is held, so the NAND latches the data on the WE# rising edge with hold time TWH.
  - It then goes to FETCH if `rem != 0`, otherwise to DONE.
- DONE: `done = 1` for one cycle and `nand_dq_oe = 0`, then IDLE.
- `fifo_rd_en` is asserted only in FETCH, only when `fifo_rempty = 0`, and at most once per byte. It is never asserted for more than `len` bytes per command.
- `rem` is LEN_W bits and never wraps, because it is only decremented while non-zero.
- A single phase counter is shared by WLOW and WHIGH. It is reloaded on entry to each state.

## Timing
- Reset values: `busy = 0`, `done = 0`, `err_uflow = 0`, `fifo_rd_en = 0`, `nand_dq_o = 0`, `nand_dq_oe = 0`, `nand_we_n = 1`. State is IDLE and `rem = 0`.
- A reset asserted mid-transfer forces these values on the next edge and abandons the remaining bytes. Bytes already popped are not restored.
- `start` accepted at edge N: FETCH and `busy = 1` from cycle N+1.
- With the buffer non-empty:
  - The pop occurs in cycle N+1.
  - WE# is low in cycles N+2 .. N+1+TWP.
  - The byte period is 1+TWP+TWH cycles (5 with defaults).
- DONE is the cycle after the last WHIGH cycle. `busy` is low from the cycle after DONE.
- An empty buffer in FETCH stretches the WE#-high time. WE# never goes low without a popped byte.
- A `start` with `len == 0` accepted at edge N gives `done = 1` in cycle N+1.

## Configuration
- Macro: `NAND_DATA_TX_UFLOW_TO_EN`.
- Defined:
  - A saturating counter counts consecutive FETCH cycles with `fifo_rempty = 1` and clears on any pop or on leaving FETCH.
  - When it reaches TO_CYC, the block goes to DONE and pulses `done` and `err_uflow` together. The remaining `rem` bytes are not sent.
- Undefined:
  - FETCH waits indefinitely.
  - `err_uflow` is tied to 0 and no counter is instantiated.

## Test plan
- Reset mid-transfer (after 2 bytes): `nand_we_n = 1`, `nand_dq_oe = 0` and `busy = 0` on the next cycle. No further pops occur.
- Buffer preloaded with 0x11, 0x22, 0x33; `start`, `len = 3`:
  - Exactly 3 pops occur.
  - 3 WE# low pulses of 2 cycles each, 5 cycles apart.
  - DQ reads 0x11, 0x22, 0x33 at the WE# rising edges.
  - `done` pulses 1 cycle after the third WHIGH. The buffer is left empty.
- `len = 0`: `done` in cycle N+1, zero pops, WE# stays high.
- Buffer empty for 20 cycles mid-transfer (macro off), then refilled:
  - WE# stays high and DQ is held for those cycles.
  - The transfer then completes with the correct byte count and no extra pop.
- Macro on, `TO_CYC = 16`, buffer empty after byte 1 of 4: `done` and `err_uflow` pulse together 16 cycles after entering FETCH, with exactly 1 pop.
- `start` pulsed while busy, plus a final byte with `len = 8191`:
  - The extra `start` is ignored.
  - 8191 WE# pulses occur with no `rem` wrap.
